// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and default widths for the core sleep controller.
//   sleep_state_e : encoding of the sleep FSM, also exported on sleep_state_o
//   *_DEF         : default parameter values used by the sleep controller
//   max_int       : helper to size a register shared by two counters
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

  localparam int NUM_BUSY_DEF   = 4;   // IF, ctrl, LSU, APU
  localparam int NUM_WAKE_DEF   = 4;   // irq, debug, timer, ext
  localparam int IDLE_CNT_W_DEF = 4;
  localparam int WAKE_DLY_W_DEF = 3;
  localparam int SLP_CNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RUN       = 3'd1,
    IDLE_WAIT = 3'd2,
    SLEEP     = 3'd3,
    WAKE      = 3'd4
  } sleep_state_e;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cv32e40p_sleep_ctrl_if.sv
// -----------------------------------------------------------------------------
// cv32e40p_sleep_ctrl_if
// Core-side sleep handshake: busy/sleep-request/wake inputs towards the sleep
// controller and the sleep status/wake cause coming back.
//   master : core/environment side (drives busy, sleep_req, wake sources)
//   slave  : sleep controller side
// -----------------------------------------------------------------------------
interface cv32e40p_sleep_ctrl_if #(
  parameter int NUM_BUSY = 4,
  parameter int NUM_WAKE = 4
);

  logic [NUM_BUSY-1:0] busy;            // per-unit busy
  logic                sleep_req;       // WFI sleep request
  logic                debug_no_sleep;  // debug forbids sleep
  logic [NUM_WAKE-1:0] wake;            // raw wake sources
  logic [NUM_WAKE-1:0] wake_mask;       // 1 = source enabled
  logic                core_sleep;      // core is asleep
  logic [NUM_WAKE-1:0] wake_cause;      // masked wake vector captured at wake

  modport master (
    output busy, sleep_req, debug_no_sleep, wake, wake_mask,
    input  core_sleep, wake_cause
  );

  modport slave (
    input  busy, sleep_req, debug_no_sleep, wake, wake_mask,
    output core_sleep, wake_cause
  );

endinterface

// File: rtl/cv32e40p_clock_gate.sv
// -----------------------------------------------------------------------------
// cv32e40p_clock_gate
// Latch-based clock gate for simulation/FPGA; replaced by a library ICG cell
// in ASIC flows.
//   clk_i        : free-running clock
//   en_i         : functional enable
//   scan_cg_en_i : test override, forces the gate open
//   clk_o        : gated clock
// -----------------------------------------------------------------------------
module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic clk_en;

  // NOTE: this is the one place a latch is intended: it is transparent while
  // clk_i is low so enable changes can never glitch the high phase of clk_o.
  always_latch begin
    if (!clk_i) begin
      clk_en <= en_i | scan_cg_en_i;
    end
  end

  assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e40p_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_sleep_ctrl
// Core sleep controller: sticky fetch enable, idle hysteresis before gating,
// maskable wake with cause capture, wake settle delay, saturating sleep
// counter. Runs on the free-running clock and drives the core clock gate.
//   clk_ungated_i / rst_n : free-running clock, async active-low reset
//   scan_cg_en_i          : force clock gate open for test
//   clk_gated_o           : gated core clock
//   fetch_enable_i/_o     : fetch enable in, sticky fetch enable out
//   bus (slave)           : busy, sleep_req, wake sources/mask, status back
//   idle_thresh_i         : idle cycles before gating (0 = gate at once)
//   wake_dly_i            : settle cycles before clock restore (0 = none)
//   sleep_state_o         : current FSM state
//   slp_cnt_clr_i         : synchronous clear of the sleep counter
//   slp_cnt_o             : saturating count of cycles spent in SLEEP
// -----------------------------------------------------------------------------
module cv32e40p_sleep_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int NUM_BUSY   = NUM_BUSY_DEF,
  parameter int NUM_WAKE   = NUM_WAKE_DEF,
  parameter int IDLE_CNT_W = IDLE_CNT_W_DEF,
  parameter int WAKE_DLY_W = WAKE_DLY_W_DEF,
  parameter int SLP_CNT_W  = SLP_CNT_W_DEF
) (
  input  logic                  clk_ungated_i,
  input  logic                  rst_n,
  input  logic                  scan_cg_en_i,
  output logic                  clk_gated_o,
  input  logic                  fetch_enable_i,
  output logic                  fetch_enable_o,
  cv32e40p_sleep_ctrl_if.slave  bus,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic [WAKE_DLY_W-1:0] wake_dly_i,
  output logic [2:0]            sleep_state_o,
  input  logic                  slp_cnt_clr_i,
  output logic [SLP_CNT_W-1:0]  slp_cnt_o
);

  // IDLE_WAIT and WAKE never overlap, so one down-counter serves both.
  localparam int CNT_W = max_int(IDLE_CNT_W, WAKE_DLY_W);

  sleep_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_WAKE-1:0] wake_cause_q, wake_cause_d;
  logic [NUM_BUSY-1:0] busy;
  logic [NUM_WAKE-1:0] masked_wake;
  logic [SLP_CNT_W-1:0] slp_cnt_q;
  logic                fetch_enable_q;
  logic                any_busy, any_wake, clock_en;

  assign busy        = bus.busy;
  assign masked_wake = bus.wake & bus.wake_mask;
  assign any_busy    = |busy;
  assign any_wake    = (|masked_wake) || bus.debug_no_sleep;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wake_cause_d = wake_cause_q;
    case (state_q)
      OFF: begin
        if (fetch_enable_q) state_d = RUN;
      end
      RUN: begin
        if (bus.sleep_req && !any_busy && !any_wake) begin
          if (idle_thresh_i == '0) begin
            state_d = SLEEP;
          end else begin
            state_d = IDLE_WAIT;
            cnt_d   = CNT_W'(idle_thresh_i);
          end
        end
      end
      IDLE_WAIT: begin
        // Abort wins over the final count so a late busy never gets gated.
        if (any_busy || !bus.sleep_req || any_wake) begin
          state_d = RUN;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = SLEEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SLEEP: begin
        if (any_wake) begin
          wake_cause_d = masked_wake;
          if (wake_dly_i == '0) begin
            state_d = RUN;
          end else begin
            state_d = WAKE;
            cnt_d   = CNT_W'(wake_dly_i);
          end
        end
      end
      WAKE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= OFF;
      cnt_q          <= '0;
      wake_cause_q   <= '0;
      fetch_enable_q <= 1'b0;
      slp_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wake_cause_q   <= wake_cause_d;
      fetch_enable_q <= fetch_enable_i | fetch_enable_q;
      if (slp_cnt_clr_i) begin
        slp_cnt_q <= '0;
      end else if (state_q == SLEEP && !(&slp_cnt_q)) begin
        slp_cnt_q <= slp_cnt_q + SLP_CNT_W'(1);
      end
    end
  end

  // Opening on next_state==RUN lets the first gated edge land on RUN entry.
  assign clock_en = fetch_enable_q &&
                    (state_q == RUN || state_q == IDLE_WAIT || state_d == RUN);

  cv32e40p_clock_gate u_core_clock_gate (
    .clk_i        (clk_ungated_i),
    .en_i         (clock_en),
    .scan_cg_en_i (scan_cg_en_i),
    .clk_o        (clk_gated_o)
  );

  assign fetch_enable_o = fetch_enable_q;
  assign sleep_state_o  = state_q;
  assign slp_cnt_o      = slp_cnt_q;
  assign bus.core_sleep = (state_q == SLEEP);
  assign bus.wake_cause = wake_cause_q;

endmodule
